// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand and result valid/ready bundle for pipelined_add_sub
interface pipelined_add_sub_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;
    modport master (
        output in_valid, a, b, mode, cin, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, mode, cin, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: CHUNK-bit-per-stage pipelined add/sub with carry, overflow and zero flags; define SATURATE_EN to clamp overflowed results to the signed limit
module pipelined_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             en;
    logic             valid_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;
    logic [WIDTH-1:0] sum_q;

    assign en            = bus.out_ready | ~valid_q;
    assign bus.in_ready  = en;
    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

    // Each stage adds the bottom slice of the operand bits still pending; pending
    // operands shrink and the finished sum grows by CHUNK bits per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int R = WIDTH - k * CHUNK;
        localparam int D = (k + 1) * CHUNK;
        logic [R-1:0]     a_i;
        logic [R-1:0]     b_i;
        logic             c_i;
        logic             v_i;
        logic [CHUNK:0]   p;
        logic [D-1:0]     s_n;
        if (k == 0) begin : g_in
            assign a_i = bus.a;
            assign b_i = bus.mode[0] ? ~bus.b : bus.b;
            assign c_i = bus.mode[1] ? bus.cin : bus.mode[0];
            assign v_i = bus.in_valid;
            assign s_n = p[CHUNK-1:0];
        end else begin : g_in
            assign a_i = g_stage[k-1].g_pipe.a_q;
            assign b_i = g_stage[k-1].g_pipe.b_q;
            assign c_i = g_stage[k-1].g_pipe.c_q;
            assign v_i = g_stage[k-1].g_pipe.v_q;
            assign s_n = {p[CHUNK-1:0], g_stage[k-1].g_pipe.s_q};
        end
        assign p = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};
        if (k < LAST) begin : g_pipe
            logic [R-CHUNK-1:0] a_q;
            logic [R-CHUNK-1:0] b_q;
            logic [D-1:0]       s_q;
            logic               c_q;
            logic               v_q;
            // Move this stage's beat forward whenever the pipeline is enabled
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (en) begin
                    v_q <= v_i;
                    a_q <= a_i[R-1:CHUNK];
                    b_q <= b_i[R-1:CHUNK];
                    s_q <= s_n;
                    c_q <= p[CHUNK];
                end
            end
        end
        if (k == LAST) begin : g_out
            logic             ovf;
            logic [WIDTH-1:0] res;
            // a_i/b_i msb here are the operand sign bits; their xor with the sum msb is the carry into the msb
            assign ovf = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ p[CHUNK-1] ^ p[CHUNK];
`ifdef SATURATE_EN
            assign res = ovf ? {a_i[CHUNK-1], {(WIDTH-1){~a_i[CHUNK-1]}}} : s_n;
`else
            assign res = s_n;
`endif
            // Register the result and flags; bubbles clear out_valid but keep the last result
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q    <= 1'b0;
                    sum_q      <= '0;
                    carry_q    <= 1'b0;
                    overflow_q <= 1'b0;
                    zero_q     <= 1'b0;
                end else if (en) begin
                    valid_q <= v_i;
                    if (v_i) begin
                        sum_q      <= res;
                        carry_q    <= p[CHUNK];
                        overflow_q <= ovf;
                        zero_q     <= ~|res;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: scoreboard bench for pipelined_add_sub at WIDTH=16, CHUNK=4
module tb_pipelined_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   emitted = 0;
    logic [18:0] sb[$];

    pipelined_add_sub_if #(.WIDTH(16)) bus();

    pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Full-width reference: {sum, carry, overflow, zero}
    function automatic logic [18:0] model(logic [1:0] m, logic [15:0] x, logic [15:0] y, logic c);
        logic [15:0] yy;
        logic        ci;
        logic [16:0] r;
        logic        v;
        logic [15:0] s;
        yy = m[0] ? ~y : y;
        ci = m[1] ? c : m[0];
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, ci};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        s  = r[15:0];
`ifdef SATURATE_EN
        if (v) s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, r[16], v, s == 16'h0000};
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output transfer
    always @(negedge clk) begin
        logic [18:0] exp;
        #2;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                emitted++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got sum=%h carry=%b ovf=%b zero=%b with nothing outstanding",
                             bus.sum, bus.carry, bus.overflow, bus.zero);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.sum, bus.carry, bus.overflow, bus.zero} !== exp) begin
                        errors++;
                        $display("FAIL result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                                 bus.sum, bus.carry, bus.overflow, bus.zero, exp[18:3], exp[2], exp[1], exp[0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.mode, bus.a, bus.b, bus.cin));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic send_single(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                               input logic c, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode = m;
        bus.a = x;
        bus.b = y;
        bus.cin = c;
        bus.out_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            #3;
            if (bus.out_valid) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.mode = 2'b00;
        bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #3;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
        if (bus.carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_vectors;
        logic [1:0]  vm[5]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [15:0] va[5]  = '{16'h7FFF, 16'h0003, 16'h0005, 16'hFFFF, 16'h0000};
        logic [15:0] vb[5]  = '{16'h0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000};
        logic        vc[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SATURATE_EN
        logic [15:0] vs[5]  = '{16'h7FFF, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFF};
`else
        logic [15:0] vs[5]  = '{16'h8000, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFF};
`endif
        logic        vco[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        vo[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vz[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            send_single(vm[i], va[i], vb[i], vc[i], lat);
            checks += 2;
            if (lat !== 4) begin errors++; $display("FAIL vec%0d_latency: got %0d want 4", i, lat); end
            if ({bus.sum, bus.carry, bus.overflow, bus.zero} !== {vs[i], vco[i], vo[i], vz[i]}) begin
                errors++;
                $display("FAIL vec%0d: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                         i, bus.sum, bus.carry, bus.overflow, bus.zero, vs[i], vco[i], vo[i], vz[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int start = emitted;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || emitted < start + 8); cyc++) begin
            @(negedge clk);
            if (!(bus.in_valid && !bus.in_ready)) begin
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.mode = 2'($urandom);
                bus.cin = 1'($urandom);
            end
            bus.in_valid = (sent < 8);
            bus.out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                errors++;
                $display("FAIL stall_in_ready cyc=%0d: got %b want %b", cyc, bus.in_ready, !(bus.out_valid && !bus.out_ready));
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        checks++;
        if (emitted - start !== 8) begin errors++; $display("FAIL stream_count: got %0d want 8", emitted - start); end
    endtask

    task automatic test_reset_in_flight;
        int start;
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            bus.mode = 2'b00;
            bus.a = 16'h1111 * 16'(i + 1);
            bus.b = 16'h0101;
            bus.cin = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        if ({bus.sum, bus.carry, bus.overflow, bus.zero} !== 19'd0) begin
            errors++;
            $display("FAIL flush_outputs: got sum=%h c=%b v=%b z=%b want all 0", bus.sum, bus.carry, bus.overflow, bus.zero);
        end
        start = emitted;
        repeat (8) @(negedge clk);
        #3;
        checks++;
        if (emitted !== start) begin errors++; $display("FAIL flush_emitted: got %0d beats want 0", emitted - start); end
        send_single(2'b01, 16'h1234, 16'h0234, 1'b0, lat);
        checks += 2;
        if (lat !== 4) begin errors++; $display("FAIL post_reset_latency: got %0d want 4", lat); end
        if (bus.sum !== 16'h1000) begin errors++; $display("FAIL post_reset_sum: got %h want 1000", bus.sum); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int sent = 0;
        int start = emitted;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 60000 && (sent < 10000 || emitted < start + 10000); cyc++) begin
            @(negedge clk);
            if (!(bus.in_valid && !bus.in_ready)) begin
                bus.a = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
                bus.b = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                bus.mode = 2'($urandom);
                bus.cin = 1'($urandom);
                bus.in_valid = (sent < 10000) && ($urandom_range(0, 4) != 0);
            end
            bus.out_ready = (sent >= 10000) || ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        checks += 2;
        if (emitted - start !== 10000) begin errors++; $display("FAIL random_count: got %0d want 10000", emitted - start); end
        if (sb.size() !== 0) begin errors++; $display("FAIL random_leftover: got %0d outstanding want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
